duty_meter: RTL and testbench

//  Receive-side counterpart of the duty-cycle ramp generator. Measures an incoming PWM waveform and reports
//  its duty cycle in tenths (0..10) on the same duty_cycle/ready interface the generator drives.

---
 rtl/duty_pkg.sv | 16 +
 rtl/duty_meter_if.sv | 15 +
 rtl/duty_quant.sv | 68 ++++++
 rtl/duty_meter.sv | 159 +++++++++++++++
 tb/tb_duty_meter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/duty_pkg.sv
// Shared types and constants for the PWM duty-cycle meter.
// Latency: n/a; backpressure: n/a.
package duty_pkg;
    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] q);
        return (q > DUTY_MAX) ? DUTY_MAX : q;
    endfunction
endpackage

// File: rtl/duty_meter_if.sv
// Control/result bundle between the duty meter and its user.
// Latency: n/a; backpressure: none, results are one-cycle pulses.
interface duty_meter_if;
    import duty_pkg::*;

    logic              en;
    logic              pwm_in;
    logic [DUTY_W-1:0] duty_cycle;
    logic              ready;
    logic              timeout;
    logic              overrun;

    modport master (output en, pwm_in, input duty_cycle, ready, timeout, overrun);
    modport slave  (input en, pwm_in, output duty_cycle, ready, timeout, overrun);
endinterface

// File: rtl/duty_quant.sv
// Rounding divider: duty = min(10, floor((10*hi + per/2) / per)), 11 fixed iterations.
// Latency: start -> done 11 cycles; backpressure: start ignored while busy.
module duty_quant
    import duty_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_hi,
    input  logic [CNT_W-1:0]  i_per,
    output logic              o_busy,
    output logic              o_done,
    output logic [DUTY_W-1:0] o_duty
);
    localparam int W = CNT_W + 4;
    localparam logic [3:0] LAST_IT = 4'd10;

    logic [W-1:0]      r_rem;
    logic [CNT_W-1:0]  r_div;
    logic [DUTY_W-1:0] r_q;
    logic [3:0]        r_it;
    logic              r_busy;

    logic [W-1:0] w_hi_x;
    logic [W-1:0] w_num;
    logic [W-1:0] w_div_x;
    logic         w_ge;

    // 10*hi as (hi<<3)+(hi<<1); the four spare bits absorb the growth
    assign w_hi_x  = {4'd0, i_hi};
    assign w_num   = (w_hi_x << 3) + (w_hi_x << 1) + {5'd0, i_per[CNT_W-1:1]};
    assign w_div_x = {4'd0, r_div};
    assign w_ge    = (r_rem >= w_div_x);

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_it == LAST_IT) && !i_abort;
    assign o_duty = clamp_duty(r_q + {3'd0, w_ge});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_it   <= '0;
            r_busy <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            if (w_ge) begin
                r_rem <= r_rem - w_div_x;
            end
            r_q  <= r_q + {3'd0, w_ge};
            r_it <= r_it + 4'd1;
            if (r_it == LAST_IT) begin
                r_busy <= 1'b0;
            end
        end else if (i_start) begin
            r_rem  <= w_num;
            r_div  <= i_per;
            r_q    <= '0;
            r_it   <= '0;
            r_busy <= 1'b1;
        end
    end
endmodule

// File: rtl/duty_meter.sv
// Measures an asynchronous PWM input and reports its duty in tenths, plus stuck-line timeouts.
// Latency: closing edge seen at E -> ready at E+12; backpressure: none, busy periods are dropped with overrun.
module duty_meter
    import duty_pkg::*;
#(
    parameter int CNT_W   = 14,
    parameter int TIMEOUT = 16383,
    parameter int SYNC_N  = 2
) (
    input  logic        clk,
    input  logic        rst,
    duty_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_N-1:0] r_sync;
    logic              r_pwm_d;
    logic              r_rise;
    state_t            r_state;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_to_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_ready;
    logic              r_timeout;
    logic              r_overrun;

    logic              w_pwm;
    logic              w_meas_edge;
    logic              w_start;
    logic              w_drop;
    logic              w_abort;
    logic              w_tracking;
    logic              w_to_hit;
    logic              w_to_fire;
    logic              w_q_busy;
    logic              w_q_done;
    logic [DUTY_W-1:0] w_q_duty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // r_pwm_d is aligned with r_rise, so the edge cycle itself counts as high
    assign w_pwm = r_sync[SYNC_N-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_N-2:0], bus.pwm_in};
            r_pwm_d <= w_pwm;
            r_rise  <= w_pwm & ~r_pwm_d;
        end
    end

    assign w_meas_edge = bus.en && (r_state == MEAS) && r_rise;
    assign w_start     = w_meas_edge && !w_q_busy;
    assign w_drop      = w_meas_edge && w_q_busy;
    assign w_abort     = !bus.en;
    assign w_tracking  = bus.en && (r_state != IDLE);
    assign w_to_hit    = w_tracking && !r_rise && (r_to_cnt == TO_LAST);
    // A pending timeout waits out any compute and the cycle after a result, keeping ready isolated
    assign w_to_fire   = w_to_hit && !w_q_busy && !r_ready;

    duty_quant #(.CNT_W(CNT_W)) u_quant (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_abort (w_abort),
        .i_hi    (r_hi_cnt),
        .i_per   (r_per_cnt),
        .o_busy  (w_q_busy),
        .o_done  (w_q_done),
        .o_duty  (w_q_duty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_to_cnt  <= '0;
            r_duty    <= '0;
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= w_drop;
            if (!bus.en) begin
                r_state   <= IDLE;
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_to_cnt  <= '0;
            end else begin
                if (w_q_done) begin
                    r_duty  <= w_q_duty;
                    r_ready <= 1'b1;
                end else if (w_to_fire) begin
                    r_duty    <= r_pwm_d ? DUTY_MAX : '0;
                    r_ready   <= 1'b1;
                    r_timeout <= 1'b1;
                end
                case (r_state)
                    IDLE: begin
                        r_state   <= ARM;
                        r_per_cnt <= '0;
                        r_hi_cnt  <= '0;
                        r_to_cnt  <= '0;
                    end
                    ARM: begin
                        if (r_rise) begin
                            r_state   <= MEAS;
                            r_per_cnt <= CNT_ONE;
                            r_hi_cnt  <= CNT_ONE;
                            r_to_cnt  <= '0;
                        end else if (w_to_fire) begin
                            r_to_cnt <= '0;
                        end else if (!w_to_hit) begin
                            r_to_cnt <= sat_inc(r_to_cnt);
                        end
                    end
                    MEAS: begin
                        if (r_rise) begin
                            r_per_cnt <= CNT_ONE;
                            r_hi_cnt  <= CNT_ONE;
                            r_to_cnt  <= '0;
                        end else if (w_to_fire) begin
                            r_state   <= ARM;
                            r_per_cnt <= '0;
                            r_hi_cnt  <= '0;
                            r_to_cnt  <= '0;
                        end else begin
                            r_per_cnt <= sat_inc(r_per_cnt);
                            if (r_pwm_d) begin
                                r_hi_cnt <= sat_inc(r_hi_cnt);
                            end
                            if (!w_to_hit) begin
                                r_to_cnt <= sat_inc(r_to_cnt);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.duty_cycle = r_duty;
    assign bus.ready      = r_ready;
    assign bus.timeout    = r_timeout;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_duty_meter.sv
// Directed bench for duty_meter: PWM periods with hand-computed duties, stuck lines, overrun, reset and enable drops.
// Expected results are queued with their cycle and matched against every ready/overrun pulse.
module tb_duty_meter;
    import duty_pkg::*;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    duty_meter_if bus();

    duty_meter #(.CNT_W(14), .TIMEOUT(TO), .SYNC_N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int duty;
        int tmo;
    } exp_t;

    exp_t exp_q[$];
    int   ov_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tb_last_duty = 0;
    logic prev_ready = 1'b0;
    int   have_prev = 0;
    int   prev_exp = 0;
    int   busy_until = -100;
    int   last_rise = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d cyc=%0d", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (prev_ready) check_eq("ready_b2b", int'(bus.ready), 0);
        if (bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_ready", int'(bus.ready), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("ready_cyc", cyc, mon_e.cyc);
                check_eq("duty", int'(bus.duty_cycle), mon_e.duty);
                check_eq("timeout_flag", int'(bus.timeout), mon_e.tmo);
                tb_last_duty = mon_e.duty;
            end
        end else if (bus.timeout === 1'b1) begin
            check_eq("timeout_alone", int'(bus.timeout), 0);
        end
        if (bus.overrun === 1'b1) begin
            if (ov_q.size() == 0) check_eq("unexp_overrun", int'(bus.overrun), 0);
            else                  check_eq("overrun_cyc", cyc, ov_q.pop_front());
        end
        prev_ready = (bus.ready === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pwm rising after posedge k: edge seen at k+3, result at k+15, overrun at k+4
    task automatic on_rise();
        exp_t e;
        if (have_prev != 0) begin
            if (cyc <= busy_until) begin
                ov_q.push_back(cyc + 4);
            end else begin
                e.cyc  = cyc + 15;
                e.duty = prev_exp;
                e.tmo  = 0;
                exp_q.push_back(e);
                busy_until = cyc + 11;
            end
        end
        last_rise = cyc;
    endtask

    task automatic drive_period(input int per, input int hi, input int exp);
        on_rise();
        prev_exp  = exp;
        have_prev = 1;
        for (int i = 0; i < per; i++) begin
            bus.pwm_in = (i < hi);
            step(1);
        end
    endtask

    task automatic run_seg(input int per, input int hi, input int n, input int exp);
        repeat (n) drive_period(per, hi, exp);
    endtask

    task automatic stuck(input logic v, input int n);
        exp_t e;
        int   c_ref;
        if (v) begin
            bus.pwm_in = 1'b1;
            on_rise();
        end
        c_ref     = last_rise;
        have_prev = 0;
        for (int k = 1; k <= n; k++) begin
            e.cyc  = c_ref + 4 + TO * k;
            e.duty = v ? 10 : 0;
            e.tmo  = 1;
            exp_q.push_back(e);
        end
        while (cyc < c_ref + TO * n + 50) begin
            if (cyc >= c_ref + TO * n + 40) bus.pwm_in = 1'b0;
            step(1);
        end
    endtask

    task automatic disrupt_rst();
        have_prev = 0;
        fork
            drive_period(70, 5, 0);
            begin
                repeat (8) @(posedge clk);
                #2 rst = 1'b0;
                #1;
                check_eq("rst_duty", int'(bus.duty_cycle), 0);
                check_eq("rst_ready", int'(bus.ready), 0);
                check_eq("rst_overrun", int'(bus.overrun), 0);
                repeat (5) @(posedge clk);
                #2 rst = 1'b1;
            end
        join
        have_prev = 0;
    endtask

    task automatic disrupt_en();
        int held;
        have_prev = 0;
        held = tb_last_duty;
        fork
            drive_period(70, 5, 0);
            begin
                repeat (8) @(posedge clk);
                #2 bus.en = 1'b0;
                repeat (10) @(negedge clk);
                check_eq("en_hold_duty", int'(bus.duty_cycle), held);
                repeat (13) @(posedge clk);
                #2 bus.en = 1'b1;
            end
        join
        check_eq("en_hold_duty_after", int'(bus.duty_cycle), held);
        have_prev = 0;
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        #2 rst = 1'b0;
        step(3);
        check_eq("reset_duty", int'(bus.duty_cycle), 0);
        check_eq("reset_ready", int'(bus.ready), 0);
        check_eq("reset_timeout", int'(bus.timeout), 0);
        check_eq("reset_overrun", int'(bus.overrun), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(2);
        bus.en = 1'b1;
        step(5);

        run_seg(70, 21, 4, 3);
        run_seg(70, 24, 2, 3);
        run_seg(70, 25, 2, 4);
        run_seg(70, 35, 2, 5);
        run_seg(71, 70, 2, 10);
        run_seg(8, 4, 6, 5);
        run_seg(70, 21, 2, 3);
        stuck(1'b0, 3);
        run_seg(70, 35, 3, 5);
        stuck(1'b1, 2);
        run_seg(70, 21, 3, 3);
        disrupt_rst();
        run_seg(70, 21, 3, 3);
        disrupt_en();
        run_seg(70, 35, 3, 5);

        have_prev = 0;
        step(30);
        check_eq("missing_ready", exp_q.size(), 0);
        check_eq("missing_overrun", ov_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
